decode_buffer: RTL and testbench
================================

# decode_buffer

Registered RV32I decode stage between fetch and execute. It decodes each fetched instruction into an `rv32i_control_word`, generates the selected immediate and flags illegal encodings. Decoded entries are held in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch and execute can stall independently. This generalises the combinational control ROM: parametrised depth, immediate generation, illegal-instruction detection and optional M-extension decode.

## Interface
- `XLEN`, 32, datapath and PC width.
- `DEPTH`, 2, FIFO entries; power of two, ≥ 2.
- `clk  in  1  clock; everything is rising-edge.`
- `rst  in  1  reset; synchronous, active-high.`
- `flush  in  1  discards all buffered entries.`
- `in_valid  in  1  fetch offers an instruction.`
- `in_ready  out  1  buffer can accept; registered, equals count < DEPTH.`
- `in_pc  in  XLEN  PC of the offered instruction.`
- `in_instr  in  32  raw instruction word.`
- `out_valid  out  1  head entry valid.`
- `out_ready  in  1  execute consumes the head.`
- `out_ctrl  out  rv32i_control_word  decoded control of the head.`
- `out_pc  out  XLEN  PC of the head.`
- `out_imm  out  XLEN  sign-extended immediate for the instruction format.`
- `out_rs1 / out_rs2 / out_rd  out  5 each  register indices; 0 when the format does not use them.`
- `out_illegal  out  1  head instruction is an illegal encoding.`
- `out_muldiv  out  1  head is an M-extension op. out_muldiv_op  out  3  M-extension funct3.`

## Operation
- Push when `in_valid && in_ready`. Decode happens combinationally at the input, and the decoded entry is written at the tail.
- Pop when `out_valid && out_ready`. All outputs are driven by the head entry.
- Count register ranges 0..DEPTH. Head and tail are log2(DEPTH)-bit pointers and wrap modulo DEPTH.
- aluop encoding: add 000, sll 001, sra 010, sub 011, xor 100, srl 101, or 110, and 111.
- cmpop equals funct3. For slt/sltu, cmpop is blt/bltu respectively.
- regfilemux_sel: 0 alu, 1 br_en, 2 u_imm, 3 mem, 4 pc+4.
- alumux1_sel: 0 rs1, 1 pc.
- alumux2_sel: 0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 rs2, 5 j_imm.
- cmpmux_sel: 0 rs2, 1 i_imm.
- Per-opcode settings:
  - lui: load_regfile, regfilemux_sel=2.
  - auipc: alu add, alumux1_sel=1, alumux2_sel=1.
  - jal: regfilemux_sel=4, pcmux_sel=1, alumux1_sel=1, alumux2_sel=5.
  - jalr: regfilemux_sel=4, pcmux_sel=1, alu add of rs1 and i_imm.
  - br: alumux1_sel=1, alumux2_sel=2, alu add.
  - load: regfilemux_sel=3, load_type word/byte/half = 0/1/2, load_unsigned for lbu/lhu.
  - store: write=1, alumux2_sel=3, store_type 0/1/2.
  - op_imm and op_reg: sub/sra are selected by funct7=0100000; slt/sltu use regfilemux_sel=1.
- Illegal encodings:
  - unknown opcode;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010;
  - branch funct3 ∈ {010, 011};
  - jalr funct3 ≠ 000;
  - op_reg funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {add, sr};
  - slli funct7 ≠ 0;
  - srli/srai funct7 ∉ {0000000, 0100000}.
- An illegal entry stores an all-zero control word (load_regfile=0, write=0), `out_illegal`=1 and the true `in_pc`.

## Timing
- Reset values: count=0, pointers=0, `out_valid`=0, `in_ready`=1. All data outputs are 0.
- Latency is 1 cycle. An instruction pushed at edge N appears on the outputs after edge N, with `out_valid`=1 if the buffer was empty.
- When full, `in_ready`=0 even if a pop occurs in the same cycle. `in_ready` rises one cycle after the pop.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Empty: `out_valid`=0. `out_ready` is ignored. Outputs hold their last value, and no check may depend on it.
- `flush` at edge N: count=0 and pointers=0 after N. A push in the same cycle is dropped, and `in_ready`=1 after N.
- Priority order: `rst` > `flush` > push/pop.
- Reset during a transfer drops all entries; the next cycle matches the reset state.

## Configuration
- `RV32M_EN` defined: op_reg with funct7=0000001 decodes as M-extension.
  - Sets `out_muldiv`=1 and `out_muldiv_op`=funct3, with load_regfile=1 and regfilemux_sel=0.
  - Not flagged illegal.
- `RV32M_EN` undefined:
  - That encoding is illegal.
  - `out_muldiv` and `out_muldiv_op` are tied to 0.

## Test plan
- Reset, then push `addi x1,x0,5` (0x00500093) at pc 0x60 with `out_ready`=1. Next cycle: `out_valid`=1, aluop add, alumux2_sel=0, `out_imm`=5, `out_rd`=1, load_regfile=1.
- Hold `out_ready`=0 and push DEPTH instructions. Required: `in_ready`=0 after the last push. Then pop and push in the same cycle: push refused, `in_ready`=1 one cycle later, order preserved.
- `sub x3,x1,x2` (0x402081B3): aluop sub, alumux2_sel=4. `lbu x5,-1(x2)` (0xFFF14283): load_type 1, load_unsigned 1, `out_imm`=0xFFFFFFFF.
- Illegal inputs 0x00003003 (load funct3 011) and 0xFFFFFFFF: `out_illegal`=1, ctrl all zero, `out_pc` preserved.
- With 2 entries buffered, assert `flush` together with `in_valid`. Next cycle: `out_valid`=0, count 0, pushed instruction absent.
- `mul x1,x2,x3` (0x023100B3):
  - with `RV32M_EN`: `out_muldiv`=1, op 000;
  - without `RV32M_EN`: `out_illegal`=1.

Source files
------------

// File: rtl/decode_buffer_if.sv
// Control-word type plus the fetch/execute handshake bundle for decode_buffer.
// Latency: n/a (declarations only).
// Backpressure: in_valid/in_ready on the fetch side, out_valid/out_ready on the execute side.
package decode_buffer_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef struct packed {
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic [2:0] regfilemux_sel;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic       cmpmux_sel;
        logic       pcmux_sel;
        logic       branch;
        logic       load_regfile;
        logic       read;
        logic       write;
        logic [1:0] load_type;
        logic       load_unsigned;
        logic [1:0] store_type;
    } rv32i_control_word;

endpackage

interface decode_buffer_if #(parameter int XLEN = 32);
    import decode_buffer_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    rv32i_control_word out_ctrl;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic              out_illegal;
    logic              out_muldiv;
    logic [2:0]        out_muldiv_op;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc, out_imm,
               out_rs1, out_rs2, out_rd, out_illegal, out_muldiv, out_muldiv_op
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc, out_imm,
               out_rs1, out_rs2, out_rd, out_illegal, out_muldiv, out_muldiv_op
    );

endinterface

// File: rtl/decode_buffer.sv
// RV32I decode into a DEPTH-entry FIFO; M-extension decode enabled by macro RV32M_EN.
// Latency: 1 cycle from accepted push to head outputs.
// Backpressure: in_ready registered (count < DEPTH), so a full buffer refuses pushes even while popping.
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    decode_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BLTU = 3'b110;

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              illegal;
        logic              muldiv;
        logic [2:0]        muldiv_op;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            push;
    logic            pop;

    logic [31:0]       instr;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    rv32i_control_word dec_ctrl;
    logic signed [31:0] imm32;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [4:0]        dec_rd;
    logic              dec_illegal;
    logic              dec_muldiv;
    logic [2:0]        dec_muldiv_op;
    entry_t            dec_entry;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec_ctrl      = '0;
        imm32         = '0;
        dec_rs1       = '0;
        dec_rs2       = '0;
        dec_rd        = '0;
        dec_illegal   = 1'b0;
        dec_muldiv    = 1'b0;
        dec_muldiv_op = '0;
        case (opcode)
            OP_LUI: begin
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = 3'd2;
                imm32  = {instr[31:12], 12'b0};
                dec_rd = instr[11:7];
            end
            OP_AUIPC: begin
                dec_ctrl.load_regfile = 1'b1;
                dec_ctrl.aluop        = ALU_ADD;
                dec_ctrl.alumux1_sel  = 1'b1;
                dec_ctrl.alumux2_sel  = 3'd1;
                imm32  = {instr[31:12], 12'b0};
                dec_rd = instr[11:7];
            end
            OP_JAL: begin
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = 3'd4;
                dec_ctrl.pcmux_sel      = 1'b1;
                dec_ctrl.alumux1_sel    = 1'b1;
                dec_ctrl.alumux2_sel    = 3'd5;
                imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_rd = instr[11:7];
            end
            OP_JALR: begin
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = 3'd4;
                dec_ctrl.pcmux_sel      = 1'b1;
                dec_ctrl.aluop          = ALU_ADD;
                imm32       = {{20{instr[31]}}, instr[31:20]};
                dec_rs1     = instr[19:15];
                dec_rd      = instr[11:7];
                dec_illegal = (funct3 != 3'b000);
            end
            OP_BR: begin
                // Target is pc + b_imm through the ALU; the comparator decides taken.
                dec_ctrl.branch      = 1'b1;
                dec_ctrl.alumux1_sel = 1'b1;
                dec_ctrl.alumux2_sel = 3'd2;
                dec_ctrl.aluop       = ALU_ADD;
                dec_ctrl.cmpop       = funct3;
                imm32       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_rs1     = instr[19:15];
                dec_rs2     = instr[24:20];
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.read           = 1'b1;
                dec_ctrl.regfilemux_sel = 3'd3;
                dec_ctrl.aluop          = ALU_ADD;
                imm32   = {{20{instr[31]}}, instr[31:20]};
                dec_rs1 = instr[19:15];
                dec_rd  = instr[11:7];
                case (funct3)
                    3'b000:  dec_ctrl.load_type = 2'd1;
                    3'b001:  dec_ctrl.load_type = 2'd2;
                    3'b010:  dec_ctrl.load_type = 2'd0;
                    3'b100:  begin dec_ctrl.load_type = 2'd1; dec_ctrl.load_unsigned = 1'b1; end
                    3'b101:  begin dec_ctrl.load_type = 2'd2; dec_ctrl.load_unsigned = 1'b1; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec_ctrl.write       = 1'b1;
                dec_ctrl.alumux2_sel = 3'd3;
                dec_ctrl.aluop       = ALU_ADD;
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_rs1 = instr[19:15];
                dec_rs2 = instr[24:20];
                case (funct3)
                    3'b000:  dec_ctrl.store_type = 2'd1;
                    3'b001:  dec_ctrl.store_type = 2'd2;
                    3'b010:  dec_ctrl.store_type = 2'd0;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec_ctrl.load_regfile = 1'b1;
                imm32   = {{20{instr[31]}}, instr[31:20]};
                dec_rs1 = instr[19:15];
                dec_rd  = instr[11:7];
                case (funct3)
                    3'b000: dec_ctrl.aluop = ALU_ADD;
                    3'b001: begin
                        dec_ctrl.aluop = ALU_SLL;
                        dec_illegal    = (funct7 != 7'b0000000);
                    end
                    3'b010: begin
                        dec_ctrl.regfilemux_sel = 3'd1;
                        dec_ctrl.cmpop          = CMP_BLT;
                        dec_ctrl.cmpmux_sel     = 1'b1;
                    end
                    3'b011: begin
                        dec_ctrl.regfilemux_sel = 3'd1;
                        dec_ctrl.cmpop          = CMP_BLTU;
                        dec_ctrl.cmpmux_sel     = 1'b1;
                    end
                    3'b100: dec_ctrl.aluop = ALU_XOR;
                    3'b101: begin
                        dec_ctrl.aluop = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        dec_illegal    = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    3'b110: dec_ctrl.aluop = ALU_OR;
                    default: dec_ctrl.aluop = ALU_AND;
                endcase
            end
            OP_REG: begin
                dec_ctrl.load_regfile = 1'b1;
                dec_ctrl.alumux2_sel  = 3'd4;
                dec_rs1 = instr[19:15];
                dec_rs2 = instr[24:20];
                dec_rd  = instr[11:7];
                if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
                    dec_muldiv    = 1'b1;
                    dec_muldiv_op = funct3;
`else
                    dec_illegal = 1'b1;
`endif
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      dec_ctrl.aluop = ALU_SUB;
                    else if (funct3 == 3'b101) dec_ctrl.aluop = ALU_SRA;
                    else                       dec_illegal    = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: dec_ctrl.aluop = ALU_ADD;
                        3'b001: dec_ctrl.aluop = ALU_SLL;
                        3'b010: begin dec_ctrl.regfilemux_sel = 3'd1; dec_ctrl.cmpop = CMP_BLT;  end
                        3'b011: begin dec_ctrl.regfilemux_sel = 3'd1; dec_ctrl.cmpop = CMP_BLTU; end
                        3'b100: dec_ctrl.aluop = ALU_XOR;
                        3'b101: dec_ctrl.aluop = ALU_SRL;
                        3'b110: dec_ctrl.aluop = ALU_OR;
                        default: dec_ctrl.aluop = ALU_AND;
                    endcase
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal entries carry only the pc and the flag, so execute cannot commit side effects.
        if (dec_illegal) begin
            dec_ctrl      = '0;
            imm32         = '0;
            dec_rs1       = '0;
            dec_rs2       = '0;
            dec_rd        = '0;
            dec_muldiv    = 1'b0;
            dec_muldiv_op = '0;
        end
    end

    always_comb begin
        dec_entry           = '0;
        dec_entry.ctrl      = dec_ctrl;
        dec_entry.pc        = bus.in_pc;
        dec_entry.imm       = XLEN'(imm32);
        dec_entry.rs1       = dec_rs1;
        dec_entry.rs2       = dec_rs2;
        dec_entry.rd        = dec_rd;
        dec_entry.illegal   = dec_illegal;
        dec_entry.muldiv    = dec_muldiv;
        dec_entry.muldiv_op = dec_muldiv_op;
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_q()) begin
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= dec_entry;
                tail      <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            count       <= count_nxt;
            in_ready_q  <= (count_nxt < FULL);
            out_valid_q <= (count_nxt != '0);
        end
    end

    function automatic logic flush_q();
        return bus.flush;
    endfunction

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_ctrl      = mem[head].ctrl;
    assign bus.out_pc        = mem[head].pc;
    assign bus.out_imm       = mem[head].imm;
    assign bus.out_rs1       = mem[head].rs1;
    assign bus.out_rs2       = mem[head].rs2;
    assign bus.out_rd        = mem[head].rd;
    assign bus.out_illegal   = mem[head].illegal;
    assign bus.out_muldiv    = mem[head].muldiv;
    assign bus.out_muldiv_op = mem[head].muldiv_op;

endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench for decode_buffer: directed vectors queued on accept, checked by a head monitor.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0]       pc;
        rv32i_control_word ctrl;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              illegal;
        logic              muldiv;
        logic [2:0]        mop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    exp_t q[$];

    decode_buffer_if #(.XLEN(XLEN)) bus ();

    decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input rv32i_control_word c, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic ill, input logic md, input logic [2:0] mop);
        exp_t e;
        e.pc = pc; e.ctrl = c; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.illegal = ill; e.muldiv = md; e.mop = mop;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a cycle; queue its expectation only if the DUT takes it.
    task automatic offer(input logic [31:0] pc, input logic [31:0] instr, input exp_t e, input logic accept);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = instr;
        @(negedge clk);
        chk($sformatf("accept_%0h", pc), 64'(bus.in_ready), 64'(accept));
        if (bus.in_ready && !bus.flush && !rst) q.push_back(e);
        step();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst || bus.flush) begin
            q.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            exp_t got;
            exp_t e;
            got = mk(bus.out_pc, bus.out_ctrl, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
                     bus.out_illegal, bus.out_muldiv, bus.out_muldiv_op);
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pop: got entry pc %0h, required no valid head", bus.out_pc);
            end else begin
                e = q.pop_front();
                if (got === e) passes++;
                else $display("FAIL head_entry pc %0h: got %h required %h", e.pc, got, e);
            end
        end
    end

    initial begin
        rv32i_control_word c;
        exp_t e;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
        chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
        chk("rst_out_imm",   64'(bus.out_imm),   64'd0);

        // Streaming decode with execute always ready.
        bus.out_ready = 1'b1;
        c = '0; c.load_regfile = 1'b1;
        offer(32'h60, 32'h00500093, mk(32'h60, c, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 3'd0), 1'b1);
        chk("first_out_valid", 64'(bus.out_valid), 64'd1);
        c = '0; c.load_regfile = 1'b1; c.aluop = 3'b011; c.alumux2_sel = 3'd4;
        offer(32'h64, 32'h402081B3, mk(32'h64, c, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0; c.load_regfile = 1'b1; c.read = 1'b1; c.regfilemux_sel = 3'd3; c.load_type = 2'd1; c.load_unsigned = 1'b1;
        offer(32'h68, 32'hFFF14283, mk(32'h68, c, 32'hFFFFFFFF, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0;
        offer(32'h6C, 32'h00003003, mk(32'h6C, c, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0), 1'b1);
        offer(32'h70, 32'hFFFFFFFF, mk(32'h70, c, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0), 1'b1);
        c = '0; c.load_regfile = 1'b1; c.regfilemux_sel = 3'd2;
        offer(32'h74, 32'h123453B7, mk(32'h74, c, 32'h12345000, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0; c.load_regfile = 1'b1; c.regfilemux_sel = 3'd4; c.pcmux_sel = 1'b1; c.alumux1_sel = 1'b1; c.alumux2_sel = 3'd5;
        offer(32'h78, 32'h008000EF, mk(32'h78, c, 32'd8, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0; c.branch = 1'b1; c.alumux1_sel = 1'b1; c.alumux2_sel = 3'd2; c.cmpop = 3'b001;
        offer(32'h7C, 32'h00209863, mk(32'h7C, c, 32'd16, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0; c.write = 1'b1; c.alumux2_sel = 3'd3;
        offer(32'h80, 32'h0020A423, mk(32'h80, c, 32'd8, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0; c.load_regfile = 1'b1; c.regfilemux_sel = 3'd1; c.cmpop = 3'b100; c.cmpmux_sel = 1'b1;
        offer(32'h84, 32'hFFE0A213, mk(32'h84, c, 32'hFFFFFFFE, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0; c.load_regfile = 1'b1; c.aluop = 3'b010;
        offer(32'h88, 32'h4030D313, mk(32'h88, c, 32'h00000403, 5'd1, 5'd0, 5'd6, 1'b0, 1'b0, 3'd0), 1'b1);
        c = '0;
        offer(32'h8C, 32'h02009093, mk(32'h8C, c, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0), 1'b1);
`ifdef RV32M_EN
        c = '0; c.load_regfile = 1'b1; c.alumux2_sel = 3'd4;
        e = mk(32'h90, c, 32'd0, 5'd2, 5'd3, 5'd1, 1'b0, 1'b1, 3'd0);
`else
        c = '0;
        e = mk(32'h90, c, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0);
`endif
        offer(32'h90, 32'h023100B3, e, 1'b1);
        step();

        // Fill with execute stalled, then pop and push together while full.
        bus.out_ready = 1'b0;
        c = '0; c.load_regfile = 1'b1;
        offer(32'h100, 32'h00100093, mk(32'h100, c, 32'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 3'd0), 1'b1);
        offer(32'h104, 32'h00200113, mk(32'h104, c, 32'd2, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 3'd0), 1'b1);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        offer(32'h108, 32'h00300193, mk(32'h108, c, 32'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 3'd0), 1'b0);
        chk("ready_after_pop", 64'(bus.in_ready), 64'd1);
        offer(32'h108, 32'h00300193, mk(32'h108, c, 32'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 3'd0), 1'b1);
        repeat (3) step();

        // Flush with two entries buffered and a simultaneous push.
        bus.out_ready = 1'b0;
        offer(32'h200, 32'h00500093, mk(32'h200, c, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 3'd0), 1'b1);
        offer(32'h204, 32'h00600113, mk(32'h204, c, 32'd6, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 3'd0), 1'b1);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h208; bus.in_instr = 32'h00700193;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("flush_push_absent", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a transfer.
        bus.out_ready = 1'b0;
        offer(32'h300, 32'h00500093, mk(32'h300, c, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 3'd0), 1'b1);
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h304; bus.in_instr = 32'h00600113; bus.out_ready = 1'b1;
        step();
        rst = 1'b0; bus.in_valid = 1'b0;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst_out_pc",    64'(bus.out_pc),    64'd0);

        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish before 100000");
        $fatal(1);
    end

endmodule
